// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: control inputs, instruction ROM port and decoder-facing outputs.
// The master modport is the fetch stage itself; slave is whoever drives it.
interface instr_fetch_if #(
  parameter int PC_W = 10
);
  logic            start;
  logic            stall;
  logic            take_branch;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] imem_addr;
  logic            imem_en;
  logic [8:0]      imem_data;
  logic [8:0]      instr;
  logic [4:0]      opcode;
  logic [3:0]      operand;
  logic [PC_W-1:0] instr_pc;
  logic            instr_valid;
  logic            done;

  modport master (
    input  start, stall, take_branch, branch_target, imem_data,
    output imem_addr, imem_en, instr, opcode, operand, instr_pc, instr_valid, done
  );

  modport slave (
    output start, stall, take_branch, branch_target, imem_data,
    input  imem_addr, imem_en, instr, opcode, operand, instr_pc, instr_valid, done
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, reads a 1-cycle synchronous ROM and
// presents a registered instruction word to the decoder.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | fetching one word per cycle, honouring stall and branch redirects
// HALT  | halt word consumed, done held high until the next start
module instr_fetch #(
  parameter int         PC_W      = 10,
  parameter logic [8:0] HALT_WORD = 9'h1FF
) (
  input  logic         clk,
  input  logic         rst_n,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] last_pc_q;
  logic [PC_W-1:0] instr_pc_q;
  logic            pend_q;
  logic [8:0]      ir_q;
  logic            valid_q;
  logic            done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      last_pc_q  <= '0;
      instr_pc_q <= '0;
      pend_q     <= 1'b0;
      ir_q       <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_HALT: begin
          if (bus.start) begin
            state_q <= S_RUN;
            pc_q    <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (bus.take_branch) begin
            // Squash both the presented word and the one still in the ROM.
            pc_q    <= bus.branch_target;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
          end else if (!bus.stall) begin
            if (valid_q && (ir_q == HALT_WORD)) begin
              state_q <= S_HALT;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              pend_q  <= 1'b0;
            end else begin
              pc_q       <= pc_q + 1'b1;
              last_pc_q  <= pc_q;
              pend_q     <= 1'b1;
              ir_q       <= bus.imem_data;
              instr_pc_q <= last_pc_q;
              valid_q    <= pend_q;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.imem_en     = (state_q == S_RUN) && !bus.stall;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = ir_q;
  assign bus.opcode      = ir_q[8:4];
  assign bus.operand     = ir_q[3:0];
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations plus a
// long randomized run checked every cycle against a queue-based fetch model.
module tb_instr_fetch;

  localparam logic [8:0] HALT = 9'h1FF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst4_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if #(.PC_W(10)) bus ();
  instr_fetch_if #(.PC_W(4))  bus4 ();

  instr_fetch #(.PC_W(10)) dut  (.clk(clk), .rst_n(rst_n),  .bus(bus.master));
  instr_fetch #(.PC_W(4))  dut4 (.clk(clk), .rst_n(rst4_n), .bus(bus4.master));

  logic [8:0] rom  [1024];
  logic [8:0] rom4 [16];

  always @(posedge clk) if (bus.imem_en)  bus.imem_data  <= rom[bus.imem_addr];
  always @(posedge clk) if (bus4.imem_en) bus4.imem_data <= rom4[bus4.imem_addr];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: fetch address, queue of addresses whose ROM word is in flight,
  // and the word currently shown to the decoder.
  typedef enum {M_IDLE, M_RUN, M_HALT} mmode_t;
  mmode_t     m_mode = M_IDLE;
  logic [9:0] m_fetch = '0;
  logic [9:0] inflight [$];
  logic       m_valid = 1'b0;
  logic       m_done  = 1'b0;
  logic [8:0] m_word  = '0;
  logic [9:0] m_pc    = '0;
  logic       m_live  = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_fetch = '0; inflight.delete();
      m_valid = 1'b0; m_done = 1'b0; m_word = '0; m_pc = '0; m_live = 1'b1;
    end else begin
      case (m_mode)
        M_IDLE, M_HALT: begin
          if (bus.start) begin
            m_mode = M_RUN; m_fetch = '0; inflight.delete(); m_done = 1'b0;
          end
        end
        M_RUN: begin
          if (bus.take_branch) begin
            m_fetch = bus.branch_target; inflight.delete(); m_valid = 1'b0;
          end else if (!bus.stall) begin
            if (m_valid && m_word == HALT) begin
              m_mode = M_HALT; m_valid = 1'b0; m_done = 1'b1; inflight.delete();
            end else begin
              m_valid = inflight.size() > 0;
              if (m_valid) begin
                m_pc   = inflight.pop_front();
                m_word = rom[m_pc];
              end
              inflight.push_back(m_fetch);
              m_fetch = m_fetch + 10'd1;
            end
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("imem_en", 32'(bus.imem_en), 32'((m_mode == M_RUN) && !bus.stall));
      if (m_mode == M_RUN) chk("imem_addr", 32'(bus.imem_addr), 32'(m_fetch));
      if (m_valid) begin
        chk("instr", 32'(bus.instr), 32'(m_word));
        chk("instr_pc", 32'(bus.instr_pc), 32'(m_pc));
        chk("opcode", 32'(bus.opcode), 32'(m_word[8:4]));
        chk("operand", 32'(bus.operand), 32'(m_word[3:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic st, input logic tb, input logic [9:0] tgt);
    bus.start = s; bus.stall = st; bus.take_branch = tb; bus.branch_target = tgt;
    #1;
  endtask

  task automatic pin_word(input string nm, input logic [9:0] pc, input logic [8:0] w);
    chk({nm, "_valid"}, 32'(bus.instr_valid), 32'd1);
    chk({nm, "_pc"}, 32'(bus.instr_pc), 32'(pc));
    chk({nm, "_instr"}, 32'(bus.instr), 32'(w));
  endtask

  logic [8:0] seq0 [4];

  initial begin
    bus.start = 0; bus.stall = 0; bus.take_branch = 0; bus.branch_target = '0;
    bus4.start = 0; bus4.stall = 0; bus4.take_branch = 0; bus4.branch_target = '0;
    for (int i = 0; i < 1024; i++) rom[i] = 9'($urandom_range(0, 510));
    seq0[0] = 9'h012; seq0[1] = 9'h0A5; seq0[2] = 9'h153; seq0[3] = 9'h1FF;
    for (int i = 0; i < 4; i++) rom[i] = seq0[i];
    rom[10'h082] = HALT;
    for (int i = 10'h200; i < 1024; i++) if ($urandom_range(0, 15) == 0) rom[i] = HALT;
    for (int i = 0; i < 16; i++) rom4[i] = 9'h010 + 9'(i);

    // reset state
    tick(); tick();
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_en", 32'(bus.imem_en), 32'd0);
    chk("rst_instr", 32'(bus.instr), 32'd0);
    chk("rst_pc", 32'(bus.instr_pc), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);

    // start -> words 012,0A5,153,1FF at c3..c6, halt at c7
    rst_n = 1; drive(1, 0, 0, '0);
    tick(); drive(0, 0, 0, '0);
    chk("c1_en", 32'(bus.imem_en), 32'd1);
    chk("c1_addr", 32'(bus.imem_addr), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick(); pin_word("seq", 10'(i), seq0[i]);
    end
    tick();
    chk("halt_done", 32'(bus.done), 32'd1);
    chk("halt_valid", 32'(bus.instr_valid), 32'd0);
    chk("halt_en", 32'(bus.imem_en), 32'd0);

    // branch in HALT ignored, then restart and stall on 0A5
    tick(); drive(0, 0, 1, 10'h040);
    tick(); drive(1, 0, 0, '0);
    chk("halt_br_done", 32'(bus.done), 32'd1);
    tick(); drive(0, 0, 0, '0);
    chk("restart_done", 32'(bus.done), 32'd0);
    chk("restart_addr", 32'(bus.imem_addr), 32'd0);
    tick(); tick();
    pin_word("restart", 10'd0, 9'h012);
    for (int i = 0; i < 3; i++) begin
      tick(); drive(0, 1, 0, '0);
      pin_word("stall", 10'd1, 9'h0A5);
      chk("stall_addr", 32'(bus.imem_addr), 32'd3);
      chk("stall_en", 32'(bus.imem_en), 32'd0);
    end
    tick(); drive(0, 0, 0, '0);
    pin_word("unstall", 10'd1, 9'h0A5);
    tick(); pin_word("resume", 10'd2, 9'h153);
    tick(); pin_word("resume", 10'd3, 9'h1FF);
    tick(); chk("resume_done", 32'(bus.done), 32'd1);

    // branch to 0x40 while instr_pc=1, then branch+stall, then branch over halt word
    tick(); drive(1, 0, 0, '0);
    tick(); drive(0, 0, 0, '0);
    tick(); tick();
    pin_word("pre_br", 10'd0, 9'h012);
    tick(); drive(0, 0, 1, 10'h040);
    pin_word("br_at", 10'd1, 9'h0A5);
    tick(); drive(0, 0, 0, '0);
    chk("br_gap1", 32'(bus.instr_valid), 32'd0);
    tick(); chk("br_gap2", 32'(bus.instr_valid), 32'd0);
    tick(); pin_word("br_tgt", 10'h040, rom[10'h040]);
    tick(); drive(0, 1, 1, 10'h080);
    pin_word("br_next", 10'h041, rom[10'h041]);
    tick(); drive(0, 0, 0, '0);
    chk("brst_gap1", 32'(bus.instr_valid), 32'd0);
    tick(); chk("brst_gap2", 32'(bus.instr_valid), 32'd0);
    tick(); pin_word("brst_tgt", 10'h080, rom[10'h080]);
    tick(); tick();
    pin_word("br_halt", 10'h082, HALT);
    drive(0, 0, 1, 10'h100);
    tick(); drive(0, 0, 0, '0);
    chk("brh_gap1", 32'(bus.instr_valid), 32'd0);
    chk("brh_done", 32'(bus.done), 32'd0);
    tick();
    tick(); pin_word("brh_tgt", 10'h100, rom[10'h100]);
    chk("brh_done2", 32'(bus.done), 32'd0);

    // randomized stream against the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_n = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 11) == 0, 10'($urandom_range(0, 1023)));
    end
    tick(); rst_n = 1; drive(0, 0, 0, '0);

    // narrow PC: wrap 14,15,0,1 then mid-stream reset
    tick(); rst4_n = 1; bus4.start = 1;
    for (int k = 1; k <= 20; k++) begin
      tick(); bus4.start = 0;
      if (k >= 17) begin
        chk("w4_valid", 32'(bus4.instr_valid), 32'd1);
        chk("w4_pc", 32'(bus4.instr_pc), 32'((k - 3) % 16));
        chk("w4_instr", 32'(bus4.instr), 32'(rom4[(k - 3) % 16]));
      end
    end
    tick(); rst4_n = 0;
    tick(); rst4_n = 1;
    chk("r4_valid", 32'(bus4.instr_valid), 32'd0);
    chk("r4_done", 32'(bus4.done), 32'd0);
    chk("r4_instr", 32'(bus4.instr), 32'd0);
    chk("r4_pc", 32'(bus4.instr_pc), 32'd0);
    chk("r4_en", 32'(bus4.imem_en), 32'd0);
    chk("r4_addr", 32'(bus4.imem_addr), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("r4_idle_en", 32'(bus4.imem_en), 32'd0);
      chk("r4_idle_valid", 32'(bus4.instr_valid), 32'd0);
    end

    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage of the 9-bit CPU, directly upstream of the decoder that splits each word into the 5-bit OP opcode and 4-bit operand field.
- Owns the program counter and drives a synchronous instruction ROM (1-cycle read latency, read-enable gated).
- Presents a registered instruction word with a valid flag, honours decoder stall and execute-stage branch redirects, and halts on the `func`/`done` instruction.

Parameters:
- PC_W, 10, program counter / ROM address width.
- HALT_WORD, 9'h1FF, encoding of {OP func (5'd31), functions done (4'd15)}; stops fetch.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin fetching at address 0; sampled in IDLE or HALT only.
- stall  input  1  decoder not accepting; hold all state.
- take_branch  input  1  redirect request from execute (jizr/jnzr/bizr/bnzr/ljp*).
- branch_target  input  PC_W  redirect address.
- imem_addr  output  PC_W  ROM read address (= pc_q).
- imem_en  output  1  ROM read enable; ROM output holds when low.
- imem_data  input  9  ROM data, valid 1 cycle after an enabled read.
- instr  output  9  registered instruction word.
- opcode  output  5  instr[8:4].
- operand  output  4  instr[3:0].
- instr_pc  output  PC_W  address of instr.
- instr_valid  output  1  instr is live for the decoder.
- done  output  1  program halted (level).

Behaviour:
- States: IDLE, RUN, HALT.
- Internal registers:
  - pc_q: current read address.
  - pend_q: imem_data holds the word for the previous enabled read.
  - last_pc_q: address of that read.
  - ir_q: instruction register.
  - valid_q: instruction valid.
- Reset (rst_n=0 at edge) dominates everything, including mid-operation. After reset: state=IDLE, pc_q=0, pend_q=0, ir_q=0, instr_pc=0, valid_q=0, done=0.
- imem_en = (state==RUN) && !stall. imem_addr = pc_q at all times.
- IDLE:
  - start=1 -> RUN, pc_q<=0, pend_q<=0.
  - take_branch is ignored.
- RUN, take_branch=1 (priority over stall and halt):
  - pc_q<=branch_target, pend_q<=0, valid_q<=0.
  - The instruction in ir_q and any in-flight ROM word are squashed.
  - The first valid word from the target appears 2 cycles later.
- RUN, stall=1, no branch: all registers hold; instr/instr_valid stay stable.
- RUN, normal cycle:
  - pc_q<=pc_q+1, wrapping from 2^PC_W-1 to 0.
  - last_pc_q<=pc_q, pend_q<=1.
  - ir_q<=imem_data, instr_pc<=last_pc_q, valid_q<=pend_q.
- Halt:
  - In a RUN cycle with valid_q=1, ir_q==HALT_WORD, !stall, !take_branch, the halt word is consumed.
  - Next state HALT, valid_q<=0, done<=1, pend_q<=0.
  - The halt word itself is presented for exactly that one cycle.
- HALT:
  - imem_en=0, done=1, outputs hold; take_branch is ignored.
  - start=1 -> RUN, pc_q<=0, pend_q<=0, done<=0.
- start while in RUN is ignored.
- Latency: start high in cycle c0 -> imem_addr=0 with imem_en in c1 -> instr_valid=1, instr=I[0], instr_pc=0 in c3. Throughput is then 1 word/cycle absent stall/branch.
- opcode and operand are pure slices of ir_q and are valid only when instr_valid=1.

Test Plan:
- Reset then start; ROM I[0..3]=9'h012,9'h0A5,9'h153,9'h1FF -> valid words 012,0A5,153,1FF on cycles c3..c6 with instr_pc 0..3; done=1 from c7, instr_valid=0, imem_en=0.
- stall held 3 cycles while instr=9'h0A5 valid -> instr, instr_pc and imem_addr unchanged, imem_en=0; the stream then resumes with 153 next, no word lost or duplicated.
- take_branch with target 10'h040 while instr_pc=1 -> instr_valid=0 for 2 cycles, then instr_pc=0x040 with I[0x40]; the word at pc 2 is never valid.
- take_branch and stall together, and take_branch in the same cycle as a valid 9'h1FF -> the branch wins, no halt, fetch resumes at target.
- PC_W=4 with a ROM free of 9'h1FF -> instr_pc sequence 14,15,0,1; rst_n=0 asserted mid-stream -> next cycle state IDLE, all outputs 0, and start is required to restart.
- From HALT, assert start -> done drops the next cycle, I[0] valid 3 cycles after start; take_branch while in HALT has no effect.
